// File: rtl/reg_file_pkg.sv
// Shared configuration for the architectural register file: default widths,
// the hardwired-zero register index and the number of read ports.
package reg_file_pkg;

  localparam int REG_NUM_DEF      = 32;
  localparam int REG_ADDR_LEN     = 5;
  localparam int DATA_LEN         = 32;
  localparam int ROB_ADDR_LEN     = 4;
  localparam int unsigned READ_PORTS = 2;

  localparam logic [REG_ADDR_LEN-1:0] ZERO_REG_ADDR = '0;

endpackage

// File: rtl/reg_file.sv
// Architectural register file with rename status (busy + producer ROB tag),
// commit write-back with same-cycle read bypass, and mispredict flush.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int REG_NUM    = REG_NUM_DEF,
  parameter int REG_ADDR_W = REG_ADDR_LEN,
  parameter int DATA_W     = DATA_LEN,
  parameter int ROB_ADDR_W = ROB_ADDR_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_dest,
  input  logic [ROB_ADDR_W-1:0] issue_robnum,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic [ROB_ADDR_W-1:0] rs1_robnum,
  output logic [DATA_W-1:0]     rs1_data,
  output logic                  rs2_busy,
  output logic [ROB_ADDR_W-1:0] rs2_robnum,
  output logic [DATA_W-1:0]     rs2_data,
  input  logic                  commit_valid,
  input  logic [REG_ADDR_W-1:0] commit_dest,
  input  logic [ROB_ADDR_W-1:0] commit_robnum,
  input  logic [DATA_W-1:0]     commit_data
);

  logic [DATA_W-1:0]     data [REG_NUM];
  logic [ROB_ADDR_W-1:0] tag  [REG_NUM];
  logic [REG_NUM-1:0]    busy;

  logic [REG_ADDR_W-1:0] rd_addr [READ_PORTS];
  logic                  rd_busy [READ_PORTS];
  logic [ROB_ADDR_W-1:0] rd_tag  [READ_PORTS];
  logic [DATA_W-1:0]     rd_data [READ_PORTS];

  // Statement order gives priority: flush clears over commit, issue overrides commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        data[i] <= '0;
        tag[i]  <= '0;
      end
    end else if (rdy) begin
      if (commit_valid && commit_dest != '0) begin
        data[commit_dest] <= commit_data;
        if (busy[commit_dest] && tag[commit_dest] == commit_robnum)
          busy[commit_dest] <= 1'b0;
      end
      if (flush) begin
        busy <= '0;
      end else if (issue_valid && issue_dest != '0) begin
        busy[issue_dest] <= 1'b1;
        tag[issue_dest]  <= issue_robnum;
      end
    end
  end

  always_comb begin
    rd_addr[0] = rs1_addr;
    rd_addr[1] = rs2_addr;
    for (int unsigned p = 0; p < READ_PORTS; p++) begin
      rd_busy[p] = busy[rd_addr[p]];
      rd_tag[p]  = tag[rd_addr[p]];
      rd_data[p] = data[rd_addr[p]];
      if (rd_addr[p] == '0) begin
        rd_busy[p] = 1'b0;
        rd_data[p] = '0;
      end else if (commit_valid && commit_dest == rd_addr[p] &&
                   busy[rd_addr[p]] && tag[rd_addr[p]] == commit_robnum) begin
        rd_busy[p] = 1'b0;
        rd_data[p] = commit_data;
      end
    end
  end

  assign rs1_busy   = rd_busy[0];
  assign rs1_robnum = rd_tag[0];
  assign rs1_data   = rd_data[0];
  assign rs2_busy   = rd_busy[1];
  assign rs2_robnum = rd_tag[1];
  assign rs2_data   = rd_data[1];

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file with rename status for the out-of-order core.
- Sits downstream of the reorder buffer's commit port and alongside issue.
- Each commit writes 32-bit results into x1..x31.
- Issue reads source operands, gets either a value or the ROB tag of the pending producer, and marks its own destination busy with its ROB number.
- A mispredict flush clears all rename state.

Parameters:
- REG_NUM, 32, number of architectural registers (x0 hardwired to zero).
- REG_ADDR_W, 5, register index width.
- DATA_W, 32, data width.
- ROB_ADDR_W, 4, ROB tag width (16-entry ROB).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rdy  in  1  global enable; when low, all state holds.
- flush  in  1  mispredict flush from ROB (has_misbranch).
- issue_valid  in  1  an instruction is issued this cycle.
- issue_dest  in  REG_ADDR_W  destination register of the issued instruction.
- issue_robnum  in  ROB_ADDR_W  ROB entry allocated to the issued instruction.
- rs1_addr  in  REG_ADDR_W  source 1 index.
- rs2_addr  in  REG_ADDR_W  source 2 index.
- rs1_busy  out  1  source 1 has a pending producer.
- rs1_robnum  out  ROB_ADDR_W  producer tag for source 1 (valid when rs1_busy).
- rs1_data  out  DATA_W  source 1 value (valid when !rs1_busy).
- rs2_busy, rs2_robnum, rs2_data  out  1/ROB_ADDR_W/DATA_W  same for source 2.
- commit_valid  in  1  ROB commit write (has_to_reg).
- commit_dest  in  REG_ADDR_W  committed destination (dest_reg_num).
- commit_robnum  in  ROB_ADDR_W  ROB entry being retired.
- commit_data  in  DATA_W  committed value (out_reg_data).

Behaviour:
- Storage: data[0..31], busy[0..31], tag[0..31].
- rst asserted (async): all data = 0, busy = 0, tag = 0. Outputs are combinational, so after reset they read busy = 0, robnum = 0, data = 0.
- State updates happen only on rising clk with rdy = 1 and rst = 0.
- x0:
  - A commit to x0 is discarded.
  - An issue to x0 never sets busy.
  - Reads of x0 always return busy = 0 and data = 0.
- Commit (commit_valid, commit_dest != 0):
  - data[commit_dest] <= commit_data unconditionally.
  - busy[commit_dest] <= 0 only if busy is set and tag[commit_dest] == commit_robnum.
  - Otherwise busy and tag are unchanged, because a younger producer still owns the register.
- Issue (issue_valid, issue_dest != 0, !flush): busy[issue_dest] <= 1 and tag[issue_dest] <= issue_robnum.
- Commit and issue to the same register in the same cycle: issue wins. Busy stays 1 with the new tag; the data write still happens.
- Flush: all busy <= 0 in one cycle, and any issue in that cycle is ignored. A commit in the same cycle still writes data, because jalr commits together with the flush.
- Read ports (combinational), computed from current state plus commit bypass:
  - If commit_valid, commit_dest == rs_addr != 0, busy[rs_addr] is set and tag[rs_addr] == commit_robnum, the port outputs busy = 0 and data = commit_data.
  - Otherwise the port outputs busy[rs_addr], tag[rs_addr] and data[rs_addr].
- Issue reads see the state before the issuing instruction's own rename. Example: add x1,x1,x2 reads the old mapping of x1.
- Reads ignore flush; issue is squashed upstream on flush.
- Latency: a write becomes visible in state 1 cycle after commit; the read bypass makes it visible in the same cycle.
- rdy low: no updates, reads stay live.

Decomposition:
- Widths (Reg_Addr_Len, Data_Len, Rob_Addr_Len), True/False and Zero_Reg_Addr live in the shared config.v.
- No sub-module. One read-port function or generate block is instantiated twice for rs1 and rs2.

Test Plan:
- Reset then read x5 -> busy = 0, data = 0. Commit x5 = 0xDEADBEEF with robnum 3 -> next cycle rs1_data = 0xDEADBEEF.
- Issue dest x7, robnum 2 -> read x7: busy = 1, robnum = 2. Commit x7, robnum 2, data 0x11 -> same-cycle bypass gives busy = 0, data 0x11; next cycle state busy = 0.
- Issue x7 with robnum 2, then x7 with robnum 5. Commit x7 with robnum 2, data 0x22 -> data[7] = 0x22, busy = 1, robnum = 5 retained.
- Same cycle: commit x9 (robnum 4, busy/tag match) and issue x9 with robnum 6 -> busy = 1, tag = 6, data updated.
- Set busy on x1, x2, x3, then assert flush together with commit x1 = 0x33 and issue x4 -> all busy = 0, data[1] = 0x33, x4 not busy.
- Issue/commit to x0 with data 0xFF -> x0 reads busy = 0, data = 0. Hold rdy = 0 during an issue -> no state change. Assert rst mid-run -> state clears immediately without waiting for a clock edge.
